// File: rtl/dmem_port_arbiter.sv
// Purpose : one-access-per-cycle arbiter that shares a single-port data RAM between IF and
//           MEM. It owns the stack pointer and has an IF anti-starvation override.
// Latency : grant and ram_* are combinational. Read data and *_rvalid appear 1 cycle after a grant.
// Backpr. : the losing requester sees *_stall=1 and holds its request until it is granted.
//
// Ports
//   clk, rst                       rising-edge clock, async active-low reset
//   if_req/if_addr                 instruction-fetch read request
//   if_stall/if_rvalid             IF denied this cycle / IF read data valid on rdata
//   mem_rd/wr/push/pop             MEM-stage op bits (priority push > pop > wr > rd)
//   mem_addr/mem_wdata             load/store address, store/push data
//   mem_stall/mem_rvalid           MEM denied this cycle / load-pop data valid on rdata
//   rdata                          returned read data (0 for an empty pop)
//   ram_en/we/addr/wdata/rdata     single-port RAM, 1-cycle synchronous read
//   sp                             current stack pointer
//   err_ovf/err_unf/err_multi      sticky: push when full / pop when empty / multiple op bits
module dmem_port_arbiter #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] STACK_TOP    = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_BOTTOM = 8'hC0,
  parameter int                STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_rvalid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_multi
);

  localparam logic [ADDR_W-1:0] SP_FULL    = STACK_BOTTOM - ADDR_W'(1);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_WR,
    OP_RD
  } mem_op_e;

  // Who the read data returning next cycle belongs to. RD_MEM_ZERO marks an
  // empty-stack pop: it still owes MEM a valid pulse, but with zero data.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_IF,
    RD_MEM,
    RD_MEM_ZERO
  } rd_owner_e;

  mem_op_e           op;
  logic [2:0]        op_cnt;
  logic              op_multi;
  logic              mem_req;
  logic              force_if;
  logic              if_grant;
  logic              mem_grant;
  logic              stack_full;
  logic              stack_empty;

  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nxt;
  logic [ADDR_W-1:0] sp_nxt;
  rd_owner_e         owner_q;
  rd_owner_e         owner_nxt;
  logic              set_ovf;
  logic              set_unf;

  // ---------------------------------------------------------------------------
  // MEM op decode: the highest-priority bit wins, extra bits are flagged.
  // ---------------------------------------------------------------------------
  always_comb begin
    op = OP_NONE;
    if (mem_push)     op = OP_PUSH;
    else if (mem_pop) op = OP_POP;
    else if (mem_wr)  op = OP_WR;
    else if (mem_rd)  op = OP_RD;
  end

  assign op_cnt   = 3'(mem_push) + 3'(mem_pop) + 3'(mem_wr) + 3'(mem_rd);
  assign op_multi = (op_cnt > 3'd1);
  assign mem_req  = (op != OP_NONE);

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == STACK_TOP);

  // ---------------------------------------------------------------------------
  // Arbitration: MEM wins by default. Once IF has been refused STARVE_MAX
  // cycles in a row, it takes this one cycle and MEM waits.
  // ---------------------------------------------------------------------------
  assign force_if  = if_req && (starve_cnt == STARVE_LIM);
  assign if_grant  = if_req && (!mem_req || force_if);
  assign mem_grant = mem_req && !force_if;
  assign if_stall  = if_req && !if_grant;
  assign mem_stall = mem_req && !mem_grant;

  // Count only consecutive refusals: the count restarts on any IF grant or
  // whenever IF stops asking.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req || if_grant) begin
      starve_nxt = 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM drive, stack pointer update and return-owner tag for the winner.
  // Full pushes and empty pops never touch the RAM, so SP cannot wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    sp_nxt    = sp;
    owner_nxt = RD_NONE;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;

    if (if_grant) begin
      ram_en    = 1'b1;
      ram_addr  = if_addr;
      owner_nxt = RD_IF;
    end else if (mem_grant) begin
      case (op)
        OP_PUSH: begin
          if (stack_full) begin
            set_ovf = 1'b1;
          end else begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = sp;
            ram_wdata = mem_wdata;
            sp_nxt    = sp - ADDR_W'(1);
          end
        end
        OP_POP: begin
          if (stack_empty) begin
            set_unf   = 1'b1;
            owner_nxt = RD_MEM_ZERO;
          end else begin
            ram_en    = 1'b1;
            ram_addr  = sp + ADDR_W'(1);
            sp_nxt    = sp + ADDR_W'(1);
            owner_nxt = RD_MEM;
          end
        end
        OP_WR: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = mem_addr;
          ram_wdata = mem_wdata;
        end
        OP_RD: begin
          ram_en    = 1'b1;
          ram_addr  = mem_addr;
          owner_nxt = RD_MEM;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops the owner tag, so a read granted just before
  // reset never produces a valid pulse afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp         <= STACK_TOP;
      starve_cnt <= 4'd0;
      owner_q    <= RD_NONE;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      sp         <= sp_nxt;
      starve_cnt <= starve_nxt;
      owner_q    <= owner_nxt;
      if (set_ovf)             err_ovf   <= 1'b1;
      if (set_unf)             err_unf   <= 1'b1;
      if (mem_req && op_multi) err_multi <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: the RAM answers one cycle after the grant. The registered tag
  // routes the valid pulse to exactly one requester.
  // ---------------------------------------------------------------------------
  assign if_rvalid  = (owner_q == RD_IF);
  assign mem_rvalid = (owner_q == RD_MEM) || (owner_q == RD_MEM_ZERO);
  assign rdata      = ((owner_q == RD_IF) || (owner_q == RD_MEM)) ? ram_rdata : '0;

endmodule
